// File: rtl/exec_sequencer_pkg.sv
// Shared constants for the execution sequencer: phase encoding,
// branch condition codes, flag bit positions and the branch evaluator.
package exec_sequencer_pkg;

    localparam int PHASE_IDLE = 0;

    localparam logic [2:0] OPC_BE  = 3'b000;
    localparam logic [2:0] OPC_BLT = 3'b001;
    localparam logic [2:0] OPC_BLE = 3'b010;
    localparam logic [2:0] OPC_BNE = 3'b011;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Branch-taken decision for a latched {S,Z,C,V} flag set; unused codes never branch.
    function automatic logic eval_branch(input logic [3:0] flags, input logic [2:0] opc);
        logic taken;
        taken = 1'b0;
        case (opc)
            OPC_BE:  taken = flags[FLAG_Z];
            OPC_BLT: taken = flags[FLAG_S] ^ flags[FLAG_V];
            OPC_BLE: taken = flags[FLAG_Z] | (flags[FLAG_S] ^ flags[FLAG_V]);
            OPC_BNE: taken = ~flags[FLAG_Z];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/exec_sequencer_button_debounce.sv
// Debouncer for an active-low panel push button. Produces exactly one
// single-cycle press pulse per hold, however long the button stays down.
module button_debounce #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'h0002_0000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    logic [31:0] low_count;

    // Count consecutive low cycles, clear on release, saturate so a long hold never wraps into a second press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            low_count <= '0;
        end else if (btn_n) begin
            low_count <= '0;
        end else if (low_count != '1) begin
            low_count <= low_count + 32'd1;
        end
    end

    assign press = (low_count == DEBOUNCE_CYCLES);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle phase sequencer: steps each instruction through its phases,
// drives the registered memory strobes, latches ALU flags for branches and
// handles run/stop, single-step, breakpoint and retired-instruction count.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int          NUM_PHASES      = 5,
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'h0002_0000,
    parameter int          ADDR_WIDTH      = 8,
    parameter int          CNT_WIDTH       = 32,
    parameter int          PW              = $clog2(NUM_PHASES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec,
    input  logic                  single_step,
    input  logic                  is_store,
    input  logic                  cond_update,
    input  logic                  is_halt,
    input  logic [3:0]            cond,
    input  logic [2:0]            opcond,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  bp_enable,
    input  logic [ADDR_WIDTH-1:0] bp_addr,
    output logic [PW-1:0]         phase,
    output logic                  mem_src,
    output logic                  mem_write,
    output logic                  stopped,
    output logic                  halted,
    output logic                  bp_hit,
    output logic [3:0]            cond_reg,
    output logic                  branch_cond,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    localparam logic [PW-1:0] ST_IDLE     = PW'(PHASE_IDLE);
    localparam logic [PW-1:0] ST_FIRST    = PW'(1);
    localparam logic [PW-1:0] ST_PRE_LAST = PW'(NUM_PHASES - 1);
    localparam logic [PW-1:0] ST_LAST     = PW'(NUM_PHASES);

    logic press;
    logic run;
    logic run_eff;
    logic bp_skip;
    logic bp_trigger;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .btn_n (exec),
        .press (press)
    );

    assign bp_trigger  = bp_enable & (pc == bp_addr) & ~bp_skip;
    assign stopped     = (phase == ST_IDLE) | halted;
    assign branch_cond = eval_branch(cond_reg, opcond);

    // Run flag as modified by this cycle's press; the phase decisions below all use this view.
    always_comb begin
        run_eff = run;
        if (press && !halted) begin
            if (!single_step) begin
                run_eff = ~run;
            end else if (phase == ST_IDLE) begin
                run_eff = 1'b1;
            end
        end
    end

    // Phase FSM with fetch/breakpoint decision in idle, strobes into the last phase and retirement out of it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase       <= ST_IDLE;
            run         <= 1'b0;
            halted      <= 1'b0;
            mem_src     <= 1'b0;
            mem_write   <= 1'b0;
            bp_hit      <= 1'b0;
            bp_skip     <= 1'b0;
            cond_reg    <= 4'b0000;
            instr_count <= '0;
        end else begin
            bp_hit <= 1'b0;
            run    <= run_eff;
            if (phase == ST_IDLE) begin
                if (run_eff) begin
                    if (bp_trigger) begin
                        run     <= 1'b0;
                        bp_hit  <= 1'b1;
                        bp_skip <= 1'b1;
                    end else begin
                        phase   <= ST_FIRST;
                        bp_skip <= 1'b0;
                    end
                end
            end else if (phase == ST_LAST) begin
                mem_src     <= 1'b0;
                mem_write   <= 1'b0;
                instr_count <= instr_count + CNT_WIDTH'(1);
                if (is_halt) begin
                    halted <= 1'b1;
                    run    <= 1'b0;
                    phase  <= ST_IDLE;
                end else if (!run_eff || single_step) begin
                    run    <= 1'b0;
                    phase  <= ST_IDLE;
                end else begin
                    phase   <= ST_FIRST;
                    bp_skip <= 1'b0;
                end
            end else begin
                if (phase == ST_PRE_LAST) begin
                    mem_src   <= 1'b1;
                    mem_write <= is_store;
                    if (cond_update) begin
                        cond_reg <= cond;
                    end
                end
                phase <= phase + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios followed by a
// randomized run, all compared every cycle against an instruction-level model.
module tb_exec_sequencer;

    localparam int NP = 5;
    localparam int DB = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          exec;
    logic          single_step;
    logic          is_store;
    logic          cond_update;
    logic          is_halt;
    logic [3:0]    cond;
    logic [2:0]    opcond;
    logic [7:0]    pc;
    logic          bp_enable;
    logic [7:0]    bp_addr;
    logic [2:0]    phase;
    logic          mem_src;
    logic          mem_write;
    logic          stopped;
    logic          halted;
    logic          bp_hit;
    logic [3:0]    cond_reg;
    logic          branch_cond;
    logic [CW-1:0] instr_count;

    int checks;
    int errors;
    int bp_seen;
    int mw_rises;

    // Reference model state: position within the current instruction (0 = none in flight)
    int       m_step;
    bit       m_run;
    bit       m_halted;
    bit       m_skip;
    bit       m_bp;
    bit       m_src;
    bit       m_wr;
    bit [3:0] m_flags;
    int       m_count;
    int       m_low;
    bit       m_pressed;
    bit       m_go;

    exec_sequencer #(
        .NUM_PHASES(NP),
        .DEBOUNCE_CYCLES(32'(DB)),
        .ADDR_WIDTH(8),
        .CNT_WIDTH(CW)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .single_step (single_step),
        .is_store    (is_store),
        .cond_update (cond_update),
        .is_halt     (is_halt),
        .cond        (cond),
        .opcond      (opcond),
        .pc          (pc),
        .bp_enable   (bp_enable),
        .bp_addr     (bp_addr),
        .phase       (phase),
        .mem_src     (mem_src),
        .mem_write   (mem_write),
        .stopped     (stopped),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .cond_reg    (cond_reg),
        .branch_cond (branch_cond),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (bp_hit === 1'b1) bp_seen++;
    always @(posedge mem_write) mw_rises++;

    function automatic logic refBranch(input bit [3:0] f, input logic [2:0] opc);
        bit s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        case (opc)
            3'd0:    return z;
            3'd1:    return s != v;
            3'd2:    return z || (s != v);
            3'd3:    return !z;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level reference: a press starts or stops execution, each instruction spans NP cycles
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_step = 0; m_run = 0; m_halted = 0; m_skip = 0; m_bp = 0;
            m_src = 0; m_wr = 0; m_flags = 0; m_count = 0; m_low = 0;
        end else begin
            m_pressed = (m_low == DB);
            m_low = exec ? 0 : ((m_low < 1000) ? m_low + 1 : m_low);
            m_go = m_run;
            if (m_pressed && !m_halted) begin
                if (!single_step) m_go = !m_run;
                else if (m_step == 0) m_go = 1;
            end
            m_bp  = 0;
            m_run = m_go;
            if (m_step == 0) begin
                if (m_go && bp_enable && pc == bp_addr && !m_skip) begin
                    m_run = 0; m_bp = 1; m_skip = 1;
                end else if (m_go) begin
                    m_step = 1; m_skip = 0;
                end
            end else if (m_step == NP) begin
                m_count = (m_count + 1) % (1 << CW);
                m_src = 0;
                m_wr  = 0;
                if (is_halt) begin
                    m_halted = 1; m_run = 0; m_step = 0;
                end else if (!m_go || single_step) begin
                    m_run = 0; m_step = 0;
                end else begin
                    m_step = 1; m_skip = 0;
                end
            end else begin
                if (m_step == NP - 1) begin
                    m_src = 1;
                    m_wr  = is_store;
                    if (cond_update) m_flags = cond;
                end
                m_step++;
            end
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".phase"},       32'(phase),       32'(m_step));
        checkValue({tag, ".mem_src"},     32'(mem_src),     32'(m_src));
        checkValue({tag, ".mem_write"},   32'(mem_write),   32'(m_wr));
        checkValue({tag, ".stopped"},     32'(stopped),     32'((m_step == 0) || m_halted));
        checkValue({tag, ".halted"},      32'(halted),      32'(m_halted));
        checkValue({tag, ".bp_hit"},      32'(bp_hit),      32'(m_bp));
        checkValue({tag, ".cond_reg"},    32'(cond_reg),    32'(m_flags));
        checkValue({tag, ".branch_cond"}, 32'(branch_cond), 32'(refBranch(m_flags, opcond)));
        checkValue({tag, ".instr_count"}, 32'(instr_count), 32'(m_count));
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checkOutput(tag);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic ss, input logic st, input logic cu, input logic hl,
                                 input logic [3:0] c, input logic [2:0] oc, input logic [7:0] p,
                                 input logic bpe, input logic [7:0] bpa);
        single_step = ss; is_store = st; cond_update = cu; is_halt = hl;
        cond = c; opcond = oc; pc = p; bp_enable = bpe; bp_addr = bpa;
    endtask

    task automatic pressButton(input int hold, input string tag);
        exec = 1'b0;
        runCycles(hold, tag);
        exec = 1'b1;
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        runCycles(1, "rst");
        reset = 1'b1;
    endtask

    logic [2:0] br_opc [5];
    logic       br_exp [5];
    int         hold_left;
    int         mw_before;

    initial begin
        checks = 0; errors = 0; bp_seen = 0; mw_rises = 0;
        br_opc = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
        br_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        reset = 1'b0;
        exec  = 1'b1;
        applyStimulus(0, 0, 0, 0, 4'h0, 3'd0, 8'h00, 0, 8'h03);
        repeat (2) @(posedge clock);
        #1;
        runCycles(1, "reset");
        checkValue("reset_phase", 32'(phase), 0);
        checkValue("reset_stopped", 32'(stopped), 1);
        checkValue("reset_count", 32'(instr_count), 0);
        reset = 1'b1;

        // Free run: held button gives one press, stop press lands on the final-phase edge
        pressButton(10, "hold");
        runCycles(20, "run");
        checkValue("run_count", 32'(instr_count), 5);
        checkValue("run_phase", 32'(phase), 1);
        pressButton(6, "stop");
        runCycles(10, "stopped");
        checkValue("stop_count", 32'(instr_count), 6);
        checkValue("stop_stopped", 32'(stopped), 1);

        // Single-step with stores
        pulseReset();
        applyStimulus(1, 1, 0, 0, 4'h0, 3'd0, 8'h00, 0, 8'h03);
        pressButton(6, "step1");
        runCycles(8, "step1_run");
        checkValue("step1_count", 32'(instr_count), 1);
        checkValue("step1_stopped", 32'(stopped), 1);
        pressButton(6, "step2");
        runCycles(8, "step2_run");
        checkValue("step2_count", 32'(instr_count), 2);

        // Halt in the second instruction, then presses are ignored
        pulseReset();
        applyStimulus(1, 0, 0, 0, 4'h0, 3'd0, 8'h00, 0, 8'h03);
        pressButton(6, "h1");
        runCycles(8, "h1_run");
        is_halt = 1'b1;
        pressButton(6, "h2");
        runCycles(8, "h2_run");
        checkValue("halt_halted", 32'(halted), 1);
        checkValue("halt_count", 32'(instr_count), 2);
        is_halt = 1'b0;
        single_step = 1'b0;
        pressButton(6, "h3");
        runCycles(8, "h3_run");
        checkValue("halt_phase", 32'(phase), 0);

        // Breakpoint at pc 3: first press hits, second press executes it
        pulseReset();
        applyStimulus(0, 0, 0, 0, 4'h0, 3'd0, 8'h03, 1, 8'h03);
        bp_seen = 0;
        pressButton(6, "bp1");
        runCycles(4, "bp1_idle");
        checkValue("bp_pulses", 32'(bp_seen), 1);
        checkValue("bp_phase", 32'(phase), 0);
        pressButton(6, "bp2");
        checkValue("bp_resume_phase", 32'(phase), 2);
        checkValue("bp_no_rehit", 32'(bp_seen), 1);
        pressButton(6, "bp_stop");
        runCycles(10, "bp_end");

        // Flags latched by an ALU instruction drive the branch decision
        pulseReset();
        applyStimulus(1, 0, 1, 0, 4'b0100, 3'd0, 8'h00, 0, 8'h03);
        pressButton(6, "cc1");
        runCycles(8, "cc1_run");
        cond_update = 1'b0;
        cond = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            opcond = br_opc[i];
            runCycles(1, "br");
            checkValue($sformatf("branch_opc%0d", br_opc[i]), 32'(branch_cond), 32'(br_exp[i]));
        end
        cond = 4'b1000;
        cond_update = 1'b1;
        pressButton(6, "cc2");
        runCycles(8, "cc2_run");
        opcond = 3'd1;
        runCycles(1, "br2");
        checkValue("branch_blt_s", 32'(branch_cond), 1);

        // Reset in phase 3 of a store drops the pending write
        pulseReset();
        applyStimulus(1, 1, 0, 0, 4'h0, 3'd0, 8'h00, 0, 8'h03);
        pressButton(6, "rs");
        runCycles(1, "rs_p3");
        checkValue("rs_phase3", 32'(phase), 3);
        mw_before = mw_rises;
        reset = 1'b0;
        #1;
        checkValue("rs_phase", 32'(phase), 0);
        checkValue("rs_mem_write", 32'(mem_write), 0);
        checkValue("rs_stopped", 32'(stopped), 1);
        @(posedge clock);
        #1;
        runCycles(2, "rs_hold");
        reset = 1'b1;
        runCycles(12, "rs_after");
        checkValue("rs_no_write", 32'(mw_rises), 32'(mw_before));

        // Randomized run
        hold_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_left == 0) begin
                exec = 1'($urandom_range(0, 1));
                hold_left = exec ? $urandom_range(1, 12) : $urandom_range(1, 8);
            end
            hold_left--;
            if ($urandom_range(0, 19) == 0) single_step = ~single_step;
            is_store    = 1'($urandom_range(0, 1));
            cond_update = 1'($urandom_range(0, 1));
            is_halt     = ($urandom_range(0, 59) == 0);
            cond        = 4'($urandom_range(0, 15));
            opcond      = 3'($urandom_range(0, 7));
            pc          = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) bp_enable = ~bp_enable;
            if (reset == 1'b0) reset = 1'b1;
            else if ($urandom_range(0, 119) == 0) reset = 1'b0;
            runCycles(1, "rand");
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Parametrised successor to the multi-cycle phase controller. It generates the per-instruction phase sequence and registered memory strobes, and holds the condition-flag register used for branch evaluation. Run/stop is driven from a debounced active-low exec button, with added single-step mode, a PC breakpoint and a retired-instruction counter. It sits beside the combinational decoder, which supplies the pre-decoded strobes consumed here.

Parameters:
NUM_PHASES, 5, number of phases per instruction; legal range >=3; the last phase is the memory/writeback phase
DEBOUNCE_CYCLES, 32'h0002_0000, consecutive low cycles on exec that register one press
ADDR_WIDTH, 8, PC / breakpoint address width
CNT_WIDTH, 32, retired-instruction counter width
PW, $clog2(NUM_PHASES+1), phase output width (derived; do not override)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
exec  in  1  run/stop push button, active-low, raw (not debounced)
single_step  in  1  1 = each accepted press runs exactly one instruction
is_store  in  1  decoded: current instruction writes memory
cond_update  in  1  decoded: ALU instruction updates flags
is_halt  in  1  decoded: HLT instruction
cond  in  4  ALU flags {S,Z,C,V}
opcond  in  3  branch condition field
pc  in  ADDR_WIDTH  current program counter
bp_enable  in  1  breakpoint enable
bp_addr  in  ADDR_WIDTH  breakpoint address
phase  out  PW  0 = idle, 1..NUM_PHASES = active phase
mem_src  out  1  memory address from datapath (high only in last phase)
mem_write  out  1  memory write strobe
stopped  out  1  1 when not executing (idle or halted)
halted  out  1  sticky; set by HLT
bp_hit  out  1  one-cycle pulse when the breakpoint stops execution
cond_reg  out  4  latched flags {S,Z,C,V}
branch_cond  out  1  branch-taken decision (combinational from cond_reg, opcond)
instr_count  out  CNT_WIDTH  retired instructions

Behaviour:
- Reset (async, active-low): phase=0, run=0, halted=0, stopped=1, mem_src=0, mem_write=0, bp_hit=0, cond_reg=0, instr_count=0, debounce count=0, bp_skip=0.
- Debounce: count increments while exec=0 and saturates; release (exec=1) clears it. A single press pulse fires on the cycle the count equals DEBOUNCE_CYCLES. A held button gives exactly one pulse.
- Press effect:
  - halted=1: ignored.
  - single_step=0: toggles run.
  - single_step=1 and phase==0: sets run for one instruction.
  - single_step=1 and phase!=0: ignored.
- Idle (phase 0): if run=1, the next edge goes to phase 1, unless a breakpoint triggers.
- Breakpoint trigger: bp_enable & pc==bp_addr & !bp_skip. On trigger:
  - phase stays 0, run<=0, bp_hit pulses for 1 cycle, bp_skip<=1.
  - bp_skip clears on the next entry to phase 1, so resuming executes the breakpointed instruction.
- Phases 1..NUM_PHASES-1: advance by 1 per clock.
- Edge NUM_PHASES-1 -> NUM_PHASES:
  - mem_src<=1, mem_write<=is_store.
  - cond_reg<=cond if cond_update.
- End of phase NUM_PHASES (mem strobes clear on this edge):
  - instr_count+1, wrapping modulo 2^CNT_WIDTH.
  - is_halt: halted<=1, run<=0, phase<=0. HLT still counts as retired.
  - else if run=0 or single_step=1: run<=0, phase<=0.
  - else: phase<=1.
- Stop press mid-instruction: run clears and the current instruction completes all phases before idling; no truncation.
- Stop press on the final-phase edge: follows the run=0 rule; no further fetch.
- stopped = (phase==0) | halted. It is combinational from registers.
- branch_cond by opcond:
  - 000 = Z.
  - 001 = S^V.
  - 010 = Z|(S^V).
  - 011 = ~Z.
  - 100-111 = 0.
  - It reflects cond_reg as latched, not the live cond.
- Reset mid-instruction: immediate return to reset values; a mem_write in flight is dropped.

Decomposition:
- Shared package: phase encoding constants (PHASE_IDLE=0), opcond codes (BE, BLT, BLE, BNE), flag bit indices (S=3, Z=2, C=1, V=0).
- One sub-module, button_debounce (params DEBOUNCE_CYCLES; ports clock, reset, btn_n, press), reused for future panel buttons.
- The phase FSM, breakpoint, counter and branch_cond logic stay in exec_sequencer.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and NUM_PHASES=5.
- Hold exec low 10 cycles, non-halt instructions: exactly one pulse at count 4; phase runs 1,2,3,4,5,1,... with mem_src high only in phase 5; instr_count increments every 5 cycles.
- single_step=1, one press, is_store=1: one instruction; mem_write=1 in phase 5 only; returns to phase 0 with stopped=1; instr_count=1. A second press runs exactly one more instruction.
- is_halt=1 in the second instruction: halted=1, phase=0, instr_count=2. Later presses leave phase at 0 until reset.
- bp_enable=1, bp_addr=8'h03, pc reaching 3 at fetch: bp_hit pulses 1 cycle, phase stays 0. The next press enters phase 1 at pc=3 without a re-hit.
- cond=4'b0100 with cond_update=1 in instr 1, then opcond 000/001/010/011/111: branch_cond=1/0/1/0/0. cond=4'b1000: 001 yields 1.
- Assert reset in phase 3 with is_store=1: all outputs return to reset values asynchronously; no mem_write pulse occurs.
